fir_mac: RTL

Tap-serial FIR multiply-accumulate engine that sits directly downstream of the equalizer's circular sample buffers. It consumes the one-sample-per-cycle burst a buffer emits while its `sequencing` flag is high, fetches the matching coefficient from an external synchronous coefficient ROM, and accumulates the products. When the burst ends it presents one filtered result per frame to the band scaling/summing stage. One instance is used per band per channel: LP, B1, B2, B3 and HP, for both L and R.

---
 rtl/fir_mac.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac.sv
// fir_mac: tap-serial FIR multiply-accumulate engine.
// Consumes one sample per sequencing cycle and emits one result per frame.
module fir_mac #(
    parameter int TAPS  = 1021,
    parameter int ACC_W = 32 + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       smpl,
    input  logic                     sequencing,
    output logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [15:0]       coef_in,
    output logic signed [31:0]       filt_out,
    output logic                     filt_vld,
    output logic                     frame_err
);

    localparam int TW = $clog2(TAPS);
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                drain_q, drain_d;
    logic [TW-1:0]             tap_q, tap_d;

    logic                      s1_vld_q, s1_vld_d;
    logic signed [15:0]        s1_smpl_q, s1_smpl_d;
    logic                      s1_first_q, s1_first_d;
    logic                      s1_last_q, s1_last_d;
    logic                      s1_err_q, s1_err_d;

    logic                      s2_vld_q, s2_vld_d;
    logic signed [31:0]        s2_prod_q, s2_prod_d;
    logic                      s2_first_q, s2_first_d;
    logic                      s2_last_q, s2_last_d;
    logic                      s2_err_q, s2_err_d;

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_shift;
    logic signed [31:0]        filt_out_q, filt_out_d;
    logic                      filt_vld_q, filt_vld_d;
    logic                      frame_err_q, frame_err_d;

    // Frame tracking: tap counter and IDLE/RUN/DRAIN state.
    always_comb begin
        tap_d   = tap_q;
        state_d = state_q;
        drain_d = drain_q;
        if (sequencing) begin
            tap_d = (tap_q == LAST_TAP) ? '0 : tap_q + TW'(1);
        end else begin
            tap_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (sequencing) state_d = RUN;
            end
            RUN: begin
                if (!sequencing) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end
            end
            DRAIN: begin
                if (sequencing) begin
                    state_d = RUN;
                end else if (drain_q == 2'd1) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline stages S1 (sample capture) and S2 (product).
    always_comb begin
        s1_vld_d   = sequencing;
        s1_smpl_d  = smpl;
        s1_first_d = sequencing && (tap_q == '0);
        s1_last_d  = sequencing && (tap_q == LAST_TAP);
        s1_err_d   = (tap_q != LAST_TAP);

        // A frame shortened by sequencing falling is only known one cycle
        // later, so the closing tag is finalised on the way into S2.
        s2_vld_d   = s1_vld_q;
        s2_prod_d  = s1_smpl_q * coef_in;
        s2_first_d = s1_vld_q && s1_first_q;
        s2_last_d  = s1_vld_q && (s1_last_q || !sequencing);
        s2_err_d   = s1_err_q;
    end

    // S3: accumulate and emit the frame result on the closing tap.
    always_comb begin
        prod_ext    = {{(ACC_W-32){s2_prod_q[31]}}, s2_prod_q};
        acc_next    = s2_first_q ? prod_ext : acc_q + prod_ext;
        acc_shift   = acc_next >>> 15;
        acc_d       = s2_vld_q ? acc_next : acc_q;
        filt_out_d  = filt_out_q;
        frame_err_d = frame_err_q;
        filt_vld_d  = 1'b0;
        if (s2_vld_q && s2_last_q) begin
            filt_out_d  = acc_shift[31:0];
            frame_err_d = s2_err_q;
            filt_vld_d  = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= 2'd0;
            tap_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_smpl_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_err_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_prod_q   <= '0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_err_q    <= 1'b0;
            acc_q       <= '0;
            filt_out_q  <= '0;
            filt_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            tap_q       <= tap_d;
            s1_vld_q    <= s1_vld_d;
            s1_smpl_q   <= s1_smpl_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_err_q    <= s1_err_d;
            s2_vld_q    <= s2_vld_d;
            s2_prod_q   <= s2_prod_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s2_err_q    <= s2_err_d;
            acc_q       <= acc_d;
            filt_out_q  <= filt_out_d;
            filt_vld_q  <= filt_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign coef_addr = tap_q;
    assign filt_out  = filt_out_q;
    assign filt_vld  = filt_vld_q;
    assign frame_err = frame_err_q;

endmodule
